mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 129 ++++++++++++
 tb/tb_mul_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential signed 32x32 multiplier, radix-16 Booth, one digit group per clock.
// Optional MUL_SEQ_EARLY_TERM_EN: finish as soon as the remaining multiplier groups recode to zero.
module mul_seq (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        load_op;
   logic        finish;
   logic        last_group;
   logic        early_stop;

   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [63:0] acc;
   logic [63:0] acc_next;
   logic [2:0]  k;

   logic [32:0]        b_ext;
   logic [4:0]         window;
   logic signed [5:0]  digit;
   logic signed [35:0] digit_wide;
   logic signed [35:0] a_wide;
   logic signed [35:0] pp;
   logic [63:0]        pp_shifted;

   // Booth window for group k: b_ext carries an implicit zero below bit 0,
   // so the window {b_reg[4k+3:4k], b_reg[4k-1]} is just a 5-bit slice.
   always_comb begin
      b_ext  = {b_reg, 1'b0};
      window = b_ext[{k, 2'b00} +: 5];
      digit  = 6'(window[0]) + 6'(window[1]) + (6'(window[2]) << 1)
             + (6'(window[3]) << 2) - (6'(window[4]) << 3);
   end

   always_comb begin
      digit_wide = {{30{digit[5]}}, digit};
      a_wide     = {{4{a_reg[31]}}, a_reg};
      pp         = digit_wide * a_wide;
      pp_shifted = {{28{pp[35]}}, pp} << {k, 2'b00};
      acc_next   = acc + pp_shifted;
   end

   assign last_group = (k == 3'd7);

`ifdef MUL_SEQ_EARLY_TERM_EN
   logic [5:0]         top_pos;
   logic signed [31:0] b_upper;

   // The remaining digits are all zero once b_reg[31:4k+3] is pure sign extension.
   always_comb begin
      top_pos    = {1'b0, k, 2'b00} + 6'd3;
      b_upper    = $signed(b_reg) >>> top_pos;
      early_stop = (b_upper == 32'sd0) || (b_upper == -32'sd1);
   end
`else
   assign early_stop = 1'b0;
`endif

   always_comb begin
      state_next = state;
      load_op    = 1'b0;
      finish     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               state_next = RUN;
               load_op    = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_group || early_stop) begin
               state_next = DONE;
               finish     = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         k     <= '0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         state <= state_next;
         if (load_op) begin
            a_reg <= A;
            b_reg <= B;
            acc   <= '0;
            k     <= '0;
         end else if (state == RUN) begin
            acc <= acc_next;
            k   <= k + 3'd1;
         end
         // Product registers only change on entry to DONE and hold otherwise.
         if (finish) begin
            {HI, LO} <= acc_next;
         end
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq; build with MUL_SEQ_EARLY_TERM_EN
// to exercise the early-termination variant.
module tb_mul_seq;

   logic        clock;
   logic        clear;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;

   int errors = 0;
   int checks = 0;

   mul_seq dut (
      .clock (clock),
      .clear (clear),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .HI    (HI),
      .LO    (LO)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference latency: 9 edges, or with early termination the first group
   // after which every remaining multiplier bit equals the sign bit.
   function automatic int exp_latency(input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
      for (int g = 0; g < 8; g++) begin
         bit same = 1'b1;
         for (int i = 4 * g + 3; i < 32; i++) begin
            if (b[i] != b[31]) same = 1'b0;
         end
         if (same) return g + 2;
      end
      return 9;
`else
      return 9;
`endif
   endfunction

   // Called at the negedge just after the start-sampling edge.
   task automatic wait_done(input int lat_in, output int lat, output int busy_cnt);
      lat      = lat_in;
      busy_cnt = 0;
      while (!done && lat < 30) begin
         if (busy) busy_cnt++;
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] exp_prod, input string tag);
      int lat;
      int busy_cnt;
      @(negedge clock);
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      A     = ~a;
      B     = ~b;
      wait_done(1, lat, busy_cnt);
      check_output({tag, "_done"}, 64'(done), 64'd1);
      check_output({tag, "_lat"}, 64'(lat), 64'(exp_latency(b)));
      check_output({tag, "_busy"}, 64'(busy_cnt), 64'(exp_latency(b) - 1));
      check_output({tag, "_prod"}, {HI, LO}, exp_prod);
      @(negedge clock);
      check_output({tag, "_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int lat;
      int busy_cnt;
      int done_cnt;

      clear = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      #12;
      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_done", 64'(done), 64'd0);
      check_output("rst_hi", 64'(HI), 64'd0);
      check_output("rst_lo", 64'(LO), 64'd0);
      @(negedge clock);
      clear = 1'b1;

      apply_stimulus(32'd7, 32'd3, 64'h0000_0000_0000_0015, "m7x3");
      apply_stimulus(32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, "mneg1x1");
      apply_stimulus(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mminxmin");
      apply_stimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "mmaxxmax");
      apply_stimulus(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, "mminxmax");
      apply_stimulus(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "mneg3x5");
      apply_stimulus(32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, "mshift");

`ifdef MUL_SEQ_EARLY_TERM_EN
      apply_stimulus(32'd5, 32'd2, 64'h0000_0000_0000_000A, "et5x2");
      apply_stimulus(32'd5, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, "et5xneg1");
`else
      // Start pulsed during RUN with new operands must be ignored.
      @(negedge clock);
      A     = 32'd2;
      B     = 32'd3;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (3) begin
         @(posedge clock);
         @(negedge clock);
      end
      A     = 32'd5;
      B     = 32'd5;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      wait_done(5, lat, busy_cnt);
      check_output("ign_lat", 64'(lat), 64'd9);
      check_output("ign_prod", {HI, LO}, 64'h6);
      done_cnt = 0;
      repeat (15) begin
         @(negedge clock);
         if (done) done_cnt++;
      end
      check_output("ign_no_second_done", 64'(done_cnt), 64'd0);
`endif

      // Back-to-back: start held in the DONE cycle launches the next multiply.
      @(negedge clock);
      A     = 32'd2;
      B     = 32'd3;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      wait_done(1, lat, busy_cnt);
      check_output("b2b_first_prod", {HI, LO}, 64'h6);
      A     = 32'd5;
      B     = 32'd7;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      check_output("b2b_no_gap", 64'(busy), 64'd1);
      check_output("b2b_hold", {HI, LO}, 64'h6);
      wait_done(1, lat, busy_cnt);
      check_output("b2b_lat", 64'(lat), 64'(exp_latency(32'd7)));
      check_output("b2b_prod", {HI, LO}, 64'h23);

`ifndef MUL_SEQ_EARLY_TERM_EN
      // Asynchronous abort in the middle of RUN.
      @(negedge clock);
      A     = 32'd9;
      B     = 32'd9;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(posedge clock);
      #2 clear = 1'b0;
      #1;
      check_output("abort_busy", 64'(busy), 64'd0);
      check_output("abort_done", 64'(done), 64'd0);
      check_output("abort_hilo", {HI, LO}, 64'd0);
      done_cnt = 0;
      repeat (3) begin
         @(negedge clock);
         if (done) done_cnt++;
      end
      check_output("abort_no_done", 64'(done_cnt), 64'd0);
`else
      @(negedge clock);
      clear = 1'b0;
      #1;
      check_output("clr_hilo", {HI, LO}, 64'd0);
`endif

      // Start accepted on the first edge after clear is released.
      clear = 1'b1;
      A     = 32'd4;
      B     = 32'd4;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      check_output("rel_accept", 64'(busy), 64'd1);
      wait_done(1, lat, busy_cnt);
      check_output("rel_lat", 64'(lat), 64'(exp_latency(32'd4)));
      check_output("rel_prod", {HI, LO}, 64'h10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
